// File: rtl/ryu_motion_ctrl.sv
// Ryu character controller: once per video frame (vsync falling edge) it
// decodes the player keys into a STAND/PUNCH/JUMP state machine, moves the
// sprite horizontally with clamping, and runs a gravity-driven jump arc.
// Every output is registered and changes only on the frame update cycle.
module ryu_motion_ctrl #(
    parameter int X_INIT       = 100,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 560,
    parameter int X_STEP       = 2,
    parameter int GROUND_Y     = 300,
    parameter int PUNCH_FRAMES = 12,
    parameter int JUMP_V0      = 12,
    parameter int GRAVITY      = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_punch,
    input  logic       key_jump,
    output logic [9:0] RyuX,
    output logic [9:0] RyuY,
    output logic [2:0] sprite,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        ST_STAND = 2'd0,
        ST_PUNCH = 2'd1,
        ST_JUMP  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(PUNCH_FRAMES + 1);

    localparam logic [2:0] SPR_STAND = 3'd0;
    localparam logic [2:0] SPR_PUNCH = 3'd1;
    localparam logic [2:0] SPR_JUMP  = 3'd2;

    // 11-bit signed views of the geometry so clamping never wraps
    localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
    localparam logic signed [10:0] STEP_S   = 11'(X_STEP);
    localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
    localparam logic signed [7:0]  V0_S     = 8'(JUMP_V0);
    localparam logic signed [7:0]  GRAV_S   = 8'(GRAVITY);
    localparam logic [CNT_W-1:0]   PUNCH_LAST = CNT_W'(PUNCH_FRAMES - 1);

    state_t             state_q;
    logic [9:0]         x_q;
    logic [9:0]         y_q;
    logic signed [7:0]  vel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         sprite_q;
    logic               vsync_d_q;
    logic               frame_tick_q;

    logic               tick_d;
    logic signed [10:0] x_ext;
    logic signed [10:0] x_lft;
    logic signed [10:0] x_rgt;
    logic [9:0]         x_mv_d;
    logic signed [10:0] y_ext;
    logic signed [10:0] vel_ext;
    logic signed [10:0] ny_d;
    logic               land_d;

    // Falling edge of the active-low vsync marks the start of a frame update
    assign tick_d = vsync_d_q & ~vsync;

    // Candidate horizontal position and jump-arc next Y for this frame
    always_comb begin
        x_ext   = {1'b0, x_q};
        x_lft   = x_ext - STEP_S;
        x_rgt   = x_ext + STEP_S;
        x_mv_d  = x_q;
        if (key_left && !key_right) begin
            x_mv_d = (x_lft < XMIN_S) ? XMIN_S[9:0] : x_lft[9:0];
        end else if (key_right && !key_left) begin
            x_mv_d = (x_rgt > XMAX_S) ? XMAX_S[9:0] : x_rgt[9:0];
        end
        y_ext   = {1'b0, y_q};
        vel_ext = {{3{vel_q[7]}}, vel_q};
        ny_d    = y_ext - vel_ext;
        land_d  = (ny_d >= GROUND_S);
    end

    // vsync edge detector and the one-cycle frame pulse
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d_q    <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            vsync_d_q    <= vsync;
            frame_tick_q <= tick_d;
        end
    end

    // Character state machine; keys are only looked at on the tick cycle
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_STAND;
            x_q      <= 10'(X_INIT);
            y_q      <= GROUND_S[9:0];
            vel_q    <= '0;
            cnt_q    <= '0;
            sprite_q <= SPR_STAND;
        end else if (tick_d) begin
            case (state_q)
                ST_STAND: begin
                    x_q <= x_mv_d;
                    if (key_jump) begin
                        state_q  <= ST_JUMP;
                        vel_q    <= V0_S;
                        sprite_q <= SPR_JUMP;
                    end else if (key_punch) begin
                        state_q  <= ST_PUNCH;
                        cnt_q    <= PUNCH_LAST;
                        sprite_q <= SPR_PUNCH;
                    end else begin
                        sprite_q <= SPR_STAND;
                    end
                end
                ST_PUNCH: begin
                    // X frozen and keys ignored until the punch runs out
                    if (cnt_q == '0) begin
                        state_q  <= ST_STAND;
                        sprite_q <= SPR_STAND;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_JUMP: begin
                    x_q <= x_mv_d;
                    if (land_d) begin
                        y_q      <= GROUND_S[9:0];
                        vel_q    <= '0;
                        state_q  <= ST_STAND;
                        sprite_q <= SPR_STAND;
                    end else begin
                        y_q   <= ny_d[9:0];
                        vel_q <= vel_q - GRAV_S;
                    end
                end
                default: begin
                    state_q  <= ST_STAND;
                    sprite_q <= SPR_STAND;
                end
            endcase
        end
    end

    assign RyuX       = x_q;
    assign RyuY       = y_q;
    assign sprite     = sprite_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ryu_motion_ctrl.sv
// Self-checking bench for ryu_motion_ctrl: a frame-level behavioural model
// is compared against the DUT every cycle, plus literal expectations for
// the clamp, jump arc, punch timing, priority and asynchronous reset.
module tb_ryu_motion_ctrl;

    logic       vga_clk   = 1'b0;
    logic       reset_n   = 1'b0;
    logic       vsync     = 1'b1;
    logic       key_left  = 1'b0;
    logic       key_right = 1'b0;
    logic       key_punch = 1'b0;
    logic       key_jump  = 1'b0;
    logic [9:0] RyuX;
    logic [9:0] RyuY;
    logic [2:0] sprite;
    logic       frame_tick;

    int total   = 0;
    int bad     = 0;
    int n_ticks = 0;
    bit chk_en  = 1'b0;

    // Frame-level model of the character
    int m_x   = 100;
    int m_y   = 300;
    int m_v   = 0;
    int m_st  = 0;   // 0 stand, 1 punch, 2 jump (also the sprite code)
    int m_cnt = 0;
    bit m_prev = 1'b1;
    bit m_tick = 1'b0;

    int jy [25] = '{288, 277, 267, 258, 250, 243, 237, 232, 228, 225, 223, 222,
                    222, 223, 225, 228, 232, 237, 243, 250, 258, 267, 277, 288, 300};

    ryu_motion_ctrl dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_punch  (key_punch),
        .key_jump   (key_jump),
        .RyuX       (RyuX),
        .RyuY       (RyuY),
        .sprite     (sprite),
        .frame_tick (frame_tick)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int hmove(input int x, input bit l, input bit r);
        if (l && !r) return (x - 2 < 0) ? 0 : x - 2;
        if (r && !l) return (x + 2 > 560) ? 560 : x + 2;
        return x;
    endfunction

    // Reference model: one update per vsync falling edge
    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_x = 100; m_y = 300; m_v = 0; m_st = 0; m_cnt = 0;
            m_prev = 1'b1; m_tick = 1'b0;
        end else begin
            m_tick = m_prev && !vsync;
            m_prev = vsync;
            if (m_tick) begin
                if (m_st == 0) begin
                    m_x = hmove(m_x, key_left, key_right);
                    if (key_jump) begin
                        m_st = 2; m_v = 12;
                    end else if (key_punch) begin
                        m_st = 1; m_cnt = 11;
                    end
                end else if (m_st == 1) begin
                    if (m_cnt == 0) m_st = 0;
                    else m_cnt = m_cnt - 1;
                end else begin
                    m_x = hmove(m_x, key_left, key_right);
                    if (m_y - m_v >= 300) begin
                        m_y = 300; m_v = 0; m_st = 0;
                    end else begin
                        m_y = m_y - m_v;
                        m_v = m_v - 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge vga_clk) begin
        if (reset_n && chk_en) begin
            chk("model_x", int'(RyuX), m_x);
            chk("model_y", int'(RyuY), m_y);
            chk("model_sprite", int'(sprite), m_st);
            chk("model_tick", int'(frame_tick), int'(m_tick));
            if (frame_tick) n_ticks++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #2;
        end
    endtask

    // One video frame: keys presented at the vsync fall, junk keys afterwards
    task automatic frame(input bit l, input bit r, input bit p, input bit j);
        int n;
        @(posedge vga_clk);
        #2;
        key_left = l; key_right = r; key_punch = p; key_jump = j;
        vsync = 1'b0;
        cyc(1);
        key_left  = 1'($urandom_range(0, 1));
        key_right = 1'($urandom_range(0, 1));
        key_punch = 1'($urandom_range(0, 1));
        key_jump  = 1'($urandom_range(0, 1));
        n = $urandom_range(0, 2);
        cyc(n);
        vsync = 1'b1;
        cyc(2);
    endtask

    initial begin
        cyc(3);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        cyc(2);
        chk("rst_x", int'(RyuX), 100);
        chk("rst_y", int'(RyuY), 300);
        chk("rst_sprite", int'(sprite), 0);
        chk("rst_tick", int'(frame_tick), 0);

        // Idle frames
        repeat (3) frame(0, 0, 0, 0);
        chk("idle_ticks", n_ticks, 3);
        chk("idle_x", int'(RyuX), 100);
        chk("idle_y", int'(RyuY), 300);
        chk("idle_sprite", int'(sprite), 0);

        // Right clamp
        for (int i = 1; i <= 240; i++) begin
            frame(0, 1, 0, 0);
            if (i == 1)   chk("right_t1", int'(RyuX), 102);
            if (i == 229) chk("right_t229", int'(RyuX), 558);
            if (i == 230) chk("right_t230", int'(RyuX), 560);
        end
        chk("right_sat", int'(RyuX), 560);

        // Left clamp
        for (int i = 1; i <= 278; i++) frame(1, 0, 0, 0);
        chk("left_x4", int'(RyuX), 4);
        frame(1, 0, 0, 0); chk("left_2", int'(RyuX), 2);
        frame(1, 0, 0, 0); chk("left_0", int'(RyuX), 0);
        frame(1, 0, 0, 0); chk("left_hold0", int'(RyuX), 0);

        // Jump arc with right held
        frame(0, 1, 0, 1);
        chk("jump_sprite", int'(sprite), 2);
        chk("jump_y0", int'(RyuY), 300);
        chk("jump_x0", int'(RyuX), 2);
        for (int k = 1; k <= 25; k++) begin
            frame(0, 1, 0, 0);
            chk("jump_y", int'(RyuY), jy[k-1]);
            chk("jump_x", int'(RyuX), 2 + 2 * k);
            chk("jump_spr", int'(sprite), (k < 25) ? 2 : 0);
        end

        // Held punch with left held
        frame(1, 0, 1, 0);
        chk("punch_spr1", int'(sprite), 1);
        chk("punch_x1", int'(RyuX), 50);
        for (int k = 2; k <= 13; k++) begin
            frame(1, 0, 1, 0);
            chk("punch_spr", int'(sprite), (k <= 12) ? 1 : 0);
            chk("punch_x", int'(RyuX), 50);
        end
        frame(1, 0, 1, 0);
        chk("punch_retrig", int'(sprite), 1);
        chk("punch_retrig_x", int'(RyuX), 48);
        repeat (12) frame(0, 0, 0, 0);
        chk("punch_done", int'(sprite), 0);

        // Jump beats punch; punch ignored while airborne
        frame(0, 0, 1, 1);
        chk("prio_jump", int'(sprite), 2);
        for (int k = 1; k <= 25; k++) begin
            frame(0, 0, 1, 0);
            chk("air_punch", int'(sprite), (k < 25) ? 2 : 0);
        end
        frame(0, 0, 1, 0);
        chk("land_punch", int'(sprite), 1);
        repeat (13) frame(0, 0, 0, 0);

        // Asynchronous reset mid-jump
        frame(0, 1, 0, 1);
        repeat (5) frame(0, 1, 0, 0);
        chk("pre_rst_y", int'(RyuY), 250);
        chk("pre_rst_x", int'(RyuX), 60);
        @(posedge vga_clk);
        #3;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_x", int'(RyuX), 100);
        chk("arst_y", int'(RyuY), 300);
        chk("arst_sprite", int'(sprite), 0);
        chk("arst_tick", int'(frame_tick), 0);
        key_left = 0; key_right = 0; key_punch = 0; key_jump = 0;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        frame(0, 1, 0, 0);
        chk("post_rst_x", int'(RyuX), 102);
        chk("post_rst_y", int'(RyuY), 300);
        chk("post_rst_spr", int'(sprite), 0);

        // Randomized play against the model
        for (int i = 0; i < 400; i++) begin
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
